array_seq_16: RTL

Control sequencer driving the control side of the 16×16 unary-rate systolic array. On a `start` pulse it runs one tile: a weight-load phase (`clr_w`/`en_w` down every column), a compute phase (row-skewed `clr_i`/`en_i`/`mac_done` for `k_len` input vectors, each held for `MAC_CYCLES` unary cycles), and a drain phase (column-skewed `clr_o`/`en_o`). It sits between the tile scheduler and the array. It paces the ifm and weight feeders through request strobes.

---
 rtl/array_seq_16_if.sv | 31 +++
 rtl/array_seq_16.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/array_seq_16_if.sv
// array_seq_16_if: tile-scheduler and array control bundle of the array sequencer.
// master = scheduler/array side, slave = the sequencer.
interface array_seq_16_if #(
    parameter int HEIGHT = 16,
    parameter int WIDTH  = 16,
    parameter int KW     = 16
);
    logic              start;
    logic [KW-1:0]     k_len;
    logic              busy;
    logic              done;
    logic              wght_req;
    logic [HEIGHT-1:0] ifm_req;
    logic [HEIGHT-1:0] en_i;
    logic [HEIGHT-1:0] clr_i;
    logic [HEIGHT-1:0] mac_done;
    logic [WIDTH-1:0]  en_w;
    logic [WIDTH-1:0]  clr_w;
    logic [WIDTH-1:0]  en_o;
    logic [WIDTH-1:0]  clr_o;

    modport master (
        output start, k_len,
        input  busy, done, wght_req, ifm_req, en_i, clr_i, mac_done, en_w, clr_w, en_o, clr_o
    );

    modport slave (
        input  start, k_len,
        output busy, done, wght_req, ifm_req, en_i, clr_i, mac_done, en_w, clr_w, en_o, clr_o
    );
endinterface

// File: rtl/array_seq_16.sv
// array_seq_16: weight-load / compute / drain control sequencer for the systolic array.
// Row 0 and column 0 controls come from the FSM; other rows/columns are shifted copies.
module array_seq_16 #(
    parameter int HEIGHT     = 16,
    parameter int WIDTH      = 16,
    parameter int MAC_CYCLES = 256,
    parameter int KW         = 16,
    parameter int DRAIN_GAP  = 2
) (
    input  logic          clk,
    input  logic          rst,
    array_seq_16_if.slave bus
);
    localparam int MW       = $clog2(MAC_CYCLES) + 1;
    localparam int PW       = $clog2(HEIGHT + WIDTH + DRAIN_GAP) + 1;
    localparam int SKEW_LEN = HEIGHT - 1 + DRAIN_GAP;

    typedef enum logic [2:0] {IDLE, WLOAD, COMPUTE, SKEW, DRAIN} state_t;

    state_t            st, ns;
    logic [PW-1:0]     p, np;
    logic [MW-1:0]     m, nm;
    logic [KW-1:0]     v, nv, kq, nk;
    logic              last_mac, last_vec;
    logic              busy_d, done_d, clr_w_d, en_w_d, clr_i_d, en_i_d, ifm_d, mac_d, clr_o_d, en_o_d;
    logic              busy_q, done_q, wght_q;
    logic [WIDTH-1:0]  clr_w_q, en_w_q, clr_o_q, en_o_q;
    logic [HEIGHT-1:0] clr_i_q, en_i_q, ifm_q, mac_q;

    assign last_mac = m == MW'(MAC_CYCLES - 1);
    assign last_vec = v == kq - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            p  <= '0;
            m  <= '0;
            v  <= '0;
            kq <= '0;
        end else begin
            st <= ns;
            p  <= np;
            m  <= nm;
            v  <= nv;
            kq <= nk;
        end
    end

    // p is the cycle index inside the current phase; in COMPUTE it only flags clr_i (0) vs en_i (1)
    always_comb begin
        ns = st;
        np = p + 1'b1;
        nm = m;
        nv = v;
        nk = kq;
        case (st)
            IDLE: begin
                np = '0;
                if (bus.start) begin
                    nk = bus.k_len;
                    ns = bus.k_len == '0 ? IDLE : WLOAD;
                end
            end
            WLOAD: begin
                if (p == PW'(HEIGHT)) begin
                    ns = COMPUTE;
                    np = '0;
                    nm = '0;
                    nv = '0;
                end
            end
            COMPUTE: begin
                np = PW'(1);
                nm = (p == '0 || last_mac) ? '0 : m + 1'b1;
                nv = p == '0 ? '0 : v + KW'(last_mac);
                if (p != '0 && last_mac && last_vec) begin
                    ns = SKEW_LEN == 0 ? DRAIN : SKEW;
                    np = '0;
                end
            end
            SKEW: begin
                if (p == PW'(SKEW_LEN - 1)) begin
                    ns = DRAIN;
                    np = '0;
                end
            end
            DRAIN: begin
                if (p == PW'(HEIGHT + WIDTH - 1)) begin
                    ns = IDLE;
                    np = '0;
                end
            end
            default: ns = IDLE;
        endcase
    end

    // Decode the coming cycle so every output leaves a flop
    always_comb begin
        busy_d  = ns != IDLE;
        clr_w_d = ns == WLOAD && np == '0;
        en_w_d  = ns == WLOAD && np != '0;
        clr_i_d = ns == COMPUTE && np == '0;
        en_i_d  = ns == COMPUTE && np != '0;
        ifm_d   = en_i_d && nm == '0;
        mac_d   = en_i_d && nm == MW'(MAC_CYCLES - 1);
        clr_o_d = ns == DRAIN && np == '0;
        en_o_d  = ns == DRAIN && np != '0 && np <= PW'(HEIGHT);
        done_d  = (st == DRAIN && p == PW'(HEIGHT + WIDTH - 1)) ||
                  (st == IDLE && bus.start && bus.k_len == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wght_q  <= 1'b0;
            clr_w_q <= '0;
            en_w_q  <= '0;
            clr_i_q <= '0;
            en_i_q  <= '0;
            ifm_q   <= '0;
            mac_q   <= '0;
            clr_o_q <= '0;
            en_o_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            wght_q  <= en_w_d;
            clr_w_q <= {WIDTH{clr_w_d}};
            en_w_q  <= {WIDTH{en_w_d}};
            clr_i_q <= (clr_i_q << 1) | HEIGHT'(clr_i_d);
            en_i_q  <= (en_i_q << 1) | HEIGHT'(en_i_d);
            ifm_q   <= (ifm_q << 1) | HEIGHT'(ifm_d);
            mac_q   <= (mac_q << 1) | HEIGHT'(mac_d);
            clr_o_q <= (clr_o_q << 1) | WIDTH'(clr_o_d);
            en_o_q  <= (en_o_q << 1) | WIDTH'(en_o_d);
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.wght_req = wght_q;
    assign bus.clr_w    = clr_w_q;
    assign bus.en_w     = en_w_q;
    assign bus.clr_i    = clr_i_q;
    assign bus.en_i     = en_i_q;
    assign bus.ifm_req  = ifm_q;
    assign bus.mac_done = mac_q;
    assign bus.clr_o    = clr_o_q;
    assign bus.en_o     = en_o_q;
endmodule
